mem_responder: RTL

// - Synthesizable memory-side responder for the simple_processor req/ack buses.
// - Serves the instruction port (read-only) and the data port (read/write) from one shared

---
 rtl/mem_responder.sv | 75 +++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: shared single-port word memory serving the imem/dmem req/ack buses
// with a fixed response latency and round-robin arbitration between the two ports.
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,
  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o
);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_rr, r_sel_d, r_we, r_iack, r_dack;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata, r_irdata, r_drdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_grant, w_sel_d, w_fire, w_unused;
  // r_rr set means dmem wins a tie; RESP accepts a new request just like IDLE
  always_comb begin
    w_grant = (r_state != WAIT) && (imem_req_i || dmem_req_i);
    w_sel_d = dmem_req_i && (!imem_req_i || r_rr);
    w_fire  = (r_state == WAIT) && (r_cnt == 4'd0);
    w_next  = w_fire ? RESP : (r_state == WAIT || w_grant) ? WAIT : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rr     <= 1'b0;
      r_iack   <= 1'b0;
      r_dack   <= 1'b0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      r_state <= w_next;
      r_iack  <= w_fire && !r_sel_d;
      r_dack  <= w_fire && r_sel_d;
      if (w_fire && !r_we && r_sel_d) r_drdata <= r_mem[r_idx];
      if (w_fire && !r_sel_d) r_irdata <= r_mem[r_idx];
      if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      else if (w_grant) begin
        r_cnt <= 4'(LATENCY - 1);
        r_rr  <= !w_sel_d;
      end
    end
  end
  // Request capture and storage carry no reset; the write is suppressed while reset is high
  always_ff @(posedge clk_i) begin
    if (w_grant && !rst_i) begin
      r_sel_d <= w_sel_d;
      r_we    <= w_sel_d && dmem_we_i;
      r_idx   <= w_sel_d ? dmem_addr_i[2 +: IW] : imem_addr_i[2 +: IW];
      r_wdata <= dmem_wdata_i;
    end
    if (w_fire && r_we && !rst_i) r_mem[r_idx] <= r_wdata;
  end
  assign w_unused     = ^{imem_addr_i, dmem_addr_i};
  assign imem_ack_o   = r_iack;
  assign dmem_ack_o   = r_dack;
  assign imem_rdata_o = r_irdata;
  assign dmem_rdata_o = r_drdata;
endmodule
